// File: rtl/multdiv_if.sv
// Execute-stage <-> multiply/divide unit handshake: one-cycle start pulses, operands,
// result with exception flag and ready pulse, and the busy stall.
interface multdiv_if #(
   parameter int WIDTH = 32
);
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add, or radix-4 Booth with MULTDIV_BOOTH_EN defined)
// and restoring divide; one operation in flight, a new start aborts the current one.
//
// state | meaning
// IDLE  | no operation, waiting for a start pulse
// MUL   | multiply iterations, then one finalize cycle
// DIV   | divide iterations (skipped on divide-by-zero), then one finalize cycle
// DONE  | result registers valid, data_resultRDY high for this single cycle
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic      clock,
   input  logic      reset,
   multdiv_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULTDIV_BOOTH_EN
   localparam int MUL_ITERS = WIDTH / 2;
`else
   localparam int MUL_ITERS = WIDTH;
`endif
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_ITERS);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   rem, dvsr;
   logic               neg_q, dvsr_zero;
   logic [WIDTH-1:0]   result_q;
   logic               exc_q;

   logic               start_mul, start_div, mul_fin, div_fin, mul_ovf;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     div_shift, div_trial;

   assign start_mul = bus.ctrl_MULT;
   assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
   assign mul_fin   = (state == MUL) && (cnt == MUL_LAST);
   assign div_fin   = (state == DIV) && ((cnt == DIV_LAST) || dvsr_zero);
   // Signed overflow: the top WIDTH+1 product bits must all equal the result sign.
   assign mul_ovf   = ~((&acc[2*WIDTH-1:WIDTH-1]) | ~(|acc[2*WIDTH-1:WIDTH-1]));

   assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
   assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

   assign div_shift = {rem, mplier[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, dvsr};

`ifdef MULTDIV_BOOTH_EN
   logic booth_prev;

   always_comb begin
      acc_step = acc;
      case ({mplier[1:0], booth_prev})
         3'b001, 3'b010: acc_step = acc + mcand;
         3'b011:         acc_step = acc + (mcand << 1);
         3'b100:         acc_step = acc - (mcand << 1);
         3'b101, 3'b110: acc_step = acc - mcand;
         default:        acc_step = acc;
      endcase
   end
`else
   // The multiplier sign bit carries weight -2^(WIDTH-1), so the last partial product subtracts.
   always_comb begin
      acc_step = acc;
      if (mplier[0]) begin
         if (cnt == MUL_LAST - CW'(1)) acc_step = acc - mcand;
         else                          acc_step = acc + mcand;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = IDLE;
         MUL:  if (mul_fin) state_nxt = DONE;
         DIV:  if (div_fin) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (start_mul)      state_nxt = MUL;
      else if (start_div) state_nxt = DIV;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         rem       <= '0;
         dvsr      <= '0;
         neg_q     <= 1'b0;
         dvsr_zero <= 1'b0;
         result_q  <= '0;
         exc_q     <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
         booth_prev <= 1'b0;
`endif
      end else if (start_mul) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
         mplier <= bus.data_operandB;
`ifdef MULTDIV_BOOTH_EN
         booth_prev <= 1'b0;
`endif
      end else if (start_div) begin
         cnt       <= '0;
         rem       <= '0;
         mplier    <= abs_a;
         dvsr      <= abs_b;
         neg_q     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
         dvsr_zero <= (bus.data_operandB == '0);
      end else begin
         case (state)
            MUL: begin
               if (mul_fin) begin
                  result_q <= acc[WIDTH-1:0];
                  exc_q    <= mul_ovf;
               end else begin
                  acc <= acc_step;
                  cnt <= cnt + CW'(1);
`ifdef MULTDIV_BOOTH_EN
                  mcand      <= mcand << 2;
                  mplier     <= mplier >> 2;
                  booth_prev <= mplier[1];
`else
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
`endif
               end
            end
            DIV: begin
               if (div_fin) begin
                  if (dvsr_zero) begin
                     result_q <= '0;
                     exc_q    <= 1'b1;
                  end else begin
                     result_q <= neg_q ? -mplier : mplier;
                     // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
                     exc_q    <= ~neg_q & mplier[WIDTH-1];
                  end
               end else begin
                  cnt <= cnt + CW'(1);
                  if (!div_trial[WIDTH]) begin
                     rem    <= div_trial[WIDTH-1:0];
                     mplier <= {mplier[WIDTH-2:0], 1'b1};
                  end else begin
                     rem    <= div_shift[WIDTH-1:0];
                     mplier <= {mplier[WIDTH-2:0], 1'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = (state == DONE);
   assign bus.busy           = (state == MUL) || (state == DIV);
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed vector table plus hand-written abort/reset sequences for multdiv_unit.
module tb_multdiv_unit;
   localparam int W = 32;
`ifdef MULTDIV_BOOTH_EN
   localparam int MUL_LAT = 17;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;
   localparam int OP_MUL = 0, OP_DIV = 1, OP_BOTH = 2;

   typedef struct {
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   multdiv_if #(.WIDTH(W)) bus ();
   multdiv_unit #(.WIDTH(W)) dut (.clock(clk), .reset(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_op(input string name, input vec_t v);
      int  k;
      bit  found;
      @(negedge clk);
      bus.data_operandA = v.a;
      bus.data_operandB = v.b;
      bus.ctrl_MULT     = (v.op != OP_DIV);
      bus.ctrl_DIV      = (v.op != OP_MUL);
      @(posedge clk);
      @(negedge clk);
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = 32'hDEADBEEF;
      bus.data_operandB = 32'h0BADF00D;
      chk({name, " busy after start"}, {31'b0, bus.busy}, 32'd1);
      k = 0;
      found = 1'b0;
      while (!found && k < 100) begin
         k++;
         @(posedge clk);
         @(negedge clk);
         if (bus.data_resultRDY) found = 1'b1;
      end
      chk({name, " latency"}, k, v.lat);
      chk({name, " result"}, bus.data_result, v.res);
      chk({name, " exception"}, {31'b0, bus.data_exception}, {31'b0, v.exc});
      chk({name, " busy at rdy"}, {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      chk({name, " rdy one cycle"}, {31'b0, bus.data_resultRDY}, 32'd0);
      chk({name, " result held"}, bus.data_result, v.res);
   endtask

   vec_t vecs[18];
   int   n_rdy, first_k;
   logic [31:0] cap_res;
   logic        cap_exc;

   initial begin
      vecs[0]  = '{OP_MUL,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, MUL_LAT};
      vecs[1]  = '{OP_MUL,  32'h00010000, 32'h00010000, 32'h00000000, 1'b1, MUL_LAT};
      vecs[2]  = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, MUL_LAT};
      vecs[3]  = '{OP_MUL,  32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1, MUL_LAT};
      vecs[4]  = '{OP_MUL,  32'h80000000, 32'd1,        32'h80000000, 1'b0, MUL_LAT};
      vecs[5]  = '{OP_MUL,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, MUL_LAT};
      vecs[6]  = '{OP_MUL,  32'hFFFFFC18, 32'd1000,     32'hFFF0BDC0, 1'b0, MUL_LAT};
      vecs[7]  = '{OP_MUL,  32'd0,        32'd12345,    32'd0,        1'b0, MUL_LAT};
      vecs[8]  = '{OP_BOTH, 32'd3,        32'd4,        32'd12,       1'b0, MUL_LAT};
      vecs[9]  = '{OP_DIV,  32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 1'b0, DIV_LAT};
      vecs[10] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, DIV_LAT};
      vecs[11] = '{OP_DIV,  32'd1234,     32'd0,        32'd0,        1'b1, 1};
      vecs[12] = '{OP_DIV,  32'd17,       32'hFFFFFFFB, 32'hFFFFFFFD, 1'b0, DIV_LAT};
      vecs[13] = '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0, DIV_LAT};
      vecs[14] = '{OP_DIV,  32'h80000000, 32'd1,        32'h80000000, 1'b0, DIV_LAT};
      vecs[15] = '{OP_DIV,  32'd3,        32'd7,        32'd0,        1'b0, DIV_LAT};
      vecs[16] = '{OP_DIV,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, DIV_LAT};
      vecs[17] = '{OP_DIV,  32'hFFFFFFFF, 32'd0,        32'd0,        1'b1, 1};

      // Reset held with a start pulse present: nothing may start.
      bus.ctrl_MULT = 1'b1;
      bus.ctrl_DIV = 1'b0;
      bus.data_operandA = 32'd5;
      bus.data_operandB = 32'd6;
      repeat (3) @(negedge clk);
      chk("reset result", bus.data_result, 32'd0);
      chk("reset exception", {31'b0, bus.data_exception}, 32'd0);
      chk("reset rdy", {31'b0, bus.data_resultRDY}, 32'd0);
      chk("reset busy", {31'b0, bus.busy}, 32'd0);
      bus.ctrl_MULT = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle busy", {31'b0, bus.busy}, 32'd0);
      chk("idle rdy", {31'b0, bus.data_resultRDY}, 32'd0);

      for (int i = 0; i < 18; i++) run_op($sformatf("vec%0d", i), vecs[i]);

      // MULT 6x7 aborted by DIV 100/10 sampled at E10.
      @(negedge clk);
      bus.data_operandA = 32'd6;
      bus.data_operandB = 32'd7;
      bus.ctrl_MULT = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ctrl_MULT = 1'b0;
      n_rdy = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.data_resultRDY) n_rdy++;
      end
      bus.data_operandA = 32'd100;
      bus.data_operandB = 32'd10;
      bus.ctrl_DIV = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ctrl_DIV = 1'b0;
      if (bus.data_resultRDY) n_rdy++;
      first_k = 0;
      cap_res = 32'hX;
      cap_exc = 1'bX;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.data_resultRDY) begin
            n_rdy++;
            if (first_k == 0) begin
               first_k = k;
               cap_res = bus.data_result;
               cap_exc = bus.data_exception;
            end
         end
      end
      chk("abort rdy count", n_rdy, 32'd1);
      chk("abort latency", first_k, DIV_LAT);
      chk("abort result", cap_res, 32'd10);
      chk("abort exception", {31'b0, cap_exc}, 32'd0);

      // Reset arriving at E5 of a divide: no result, registers cleared.
      @(negedge clk);
      bus.data_operandA = 32'd99;
      bus.data_operandB = 32'd9;
      bus.ctrl_DIV = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ctrl_DIV = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset busy", {31'b0, bus.busy}, 32'd0);
      chk("midreset result", bus.data_result, 32'd0);
      rst_n = 1'b1;
      n_rdy = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.data_resultRDY || bus.busy) n_rdy++;
      end
      chk("midreset no rdy", n_rdy, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
